// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small circular FIFO over a valid/ready handshake.
// Bytes go out LSB-first, back-to-back, at clk_freq/baud_rate cycles per bit.
module uart_tx_fifo #(
  parameter int clk_freq   = 100_000_000,
  parameter int baud_rate  = 921_600,
  parameter int fifo_depth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       busy
);

  localparam int BIT_CLKS = clk_freq / baud_rate;
  localparam int BW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int PW       = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW       = $clog2(fifo_depth + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            txd_q;

  logic [7:0]      mem_q [fifo_depth];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            baud_wrap;
  logic            push;
  logic            pop;

  assign baud_wrap = (baud_q == BW'(BIT_CLKS - 1));
  assign tx_ready  = (cnt_q != CW'(fifo_depth));
  assign push      = tx_valid && tx_ready;
  // A pop happens either from IDLE or at the last cycle of STOP, so frames chain with no gap.
  assign pop       = (cnt_q != '0) && ((state_q == IDLE) || ((state_q == STOP) && baud_wrap));
  assign TxD       = txd_q;
  assign busy      = (state_q != IDLE) || (cnt_q != '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_q];
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_q];
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-position model checked every cycle, a line decoder,
// and directed scenarios with hand-computed edge numbers and bytes.
module tb_uart_tx_fifo;

  localparam int B     = 10;
  localparam int FL    = 10 * B;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, TxD, busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  uart_tx_fifo #(
    .clk_freq  (1_000_000),
    .baud_rate (100_000),
    .fifo_depth(DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TxD     (TxD),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Model: a queue of waiting bytes plus the position inside the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  bit         m_in;
  int         m_t;

  always @(posedge clk or negedge reset) begin
    bit acc, start;
    if (!reset) begin
      m_q.delete();
      m_in = 0;
      m_t  = 0;
    end else begin
      acc   = tx_valid && (m_q.size() < DEPTH);
      start = (m_q.size() > 0) && (!m_in || m_t == FL - 1);
      if (start) begin
        m_cur = m_q.pop_front();
        m_in  = 1;
        m_t   = 0;
      end else if (m_in) begin
        if (m_t == FL - 1) m_in = 0;
        else m_t++;
      end
      if (acc) m_q.push_back(tx_data);
    end
  end

  function automatic logic exp_txd();
    int slot;
    if (!m_in) return 1'b1;
    slot = m_t / B;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  always @(negedge clk) begin
    check("txd",   TxD,      exp_txd());
    check("busy",  busy,     m_in || (m_q.size() > 0));
    check("ready", tx_ready, m_q.size() < DEPTH);
  end

  // Line decoder: samples mid-bit after each falling edge.
  logic [7:0] rx_b[$];
  int         rx_s[$];
  bit         hunting = 1;
  bit         prevtx = 1;
  int         st;
  logic [7:0] sh;
  bit         prev_busy = 0;
  int         fall_edge = -1;

  always @(negedge clk) begin
    int off, j;
    if (!reset) begin
      hunting = 1;
      prevtx  = 1;
    end else begin
      if (hunting) begin
        if (prevtx && !TxD) begin
          hunting = 0;
          st = cyc;
        end
      end else begin
        off = cyc - st;
        if (off % B == B / 2) begin
          j = off / B;
          if (j == 0) check("start_bit", TxD, 1'b0);
          else if (j <= 8) sh[j-1] = TxD;
          else begin
            check("stop_bit", TxD, 1'b1);
            rx_b.push_back(sh);
            rx_s.push_back(st);
            hunting = 1;
          end
        end
      end
      prevtx = TxD;
    end
    if (prev_busy && !busy) fall_edge = cyc;
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, output int e);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    e = cyc;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) tick();
    check("reach_edge", cyc, target);
  endtask

  task automatic wait_quiet();
    int i;
    for (i = 0; i < 3000; i++) begin
      tick();
      if (!busy && !m_in && m_q.size() == 0) break;
    end
    check("drain_timeout", i < 3000, 1'b1);
    repeat (10) tick();
    check("idle_txd", TxD, 1'b1);
  endtask

  task automatic clear_rx();
    rx_b.delete();
    rx_s.delete();
  endtask

  initial begin
    int n, e, acc;
    bit r;

    #12;
    check("rst_txd",   TxD,      1'b1);
    check("rst_busy",  busy,     1'b0);
    check("rst_ready", tx_ready, 1'b1);
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (3) tick();

    // Single byte 0xA5
    clear_rx();
    push(8'hA5, n);
    wait_quiet();
    check("t1_count", rx_b.size(), 1);
    check("t1_byte",  rx_b[0], 8'hA5);
    check("t1_start", rx_s[0], n + 1);
    check("t1_fall",  fall_edge, n + 101);

    // Back-to-back 0x00, 0xFF
    clear_rx();
    push(8'h00, n);
    push(8'hFF, e);
    wait_quiet();
    check("t2_count",  rx_b.size(), 2);
    check("t2_byte0",  rx_b[0], 8'h00);
    check("t2_byte1",  rx_b[1], 8'hFF);
    check("t2_start0", rx_s[0], n + 1);
    check("t2_start1", rx_s[1], n + 101);

    // FIFO full, then a changing source while not ready
    clear_rx();
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(k + 1);
      r = tx_ready;
      tick();
      if (k == 0) n = cyc;
      if (r) acc++;
      if (k == 3) check("t3_ready_n3", tx_ready, 1'b1);
      if (k == 4) check("t3_ready_n4", tx_ready, 1'b0);
    end
    check("t3_accepted", acc, 5);
    e = -1;
    for (int i = 0; i < 300; i++) begin
      tx_data = tx_ready ? 8'h06 : (8'hC0 | 8'(i));
      r = tx_ready;
      tick();
      if (r) begin
        e = cyc;
        break;
      end
    end
    tx_valid = 1'b0;
    check("t3_accept_edge", e, n + 102);
    wait_quiet();
    check("t3_count", rx_b.size(), 6);
    for (int k = 0; k < 6; k++) check("t3_order", rx_b[k], 8'(k + 1));

    // Push on the exact edge frame 1's STOP ends, count 1
    clear_rx();
    push(8'h11, n);
    push(8'h22, e);
    wait_until(n + 100);
    push(8'h33, e);
    check("t4_push_edge", e, n + 101);
    check("t4_ready", tx_ready, 1'b1);
    check("t4_busy",  busy, 1'b1);
    wait_quiet();
    check("t4_count",  rx_b.size(), 3);
    check("t4_b0",     rx_b[0], 8'h11);
    check("t4_b1",     rx_b[1], 8'h22);
    check("t4_b2",     rx_b[2], 8'h33);
    check("t4_start1", rx_s[1], n + 101);
    check("t4_start2", rx_s[2], n + 201);

    // Reset in data bit 3 of 0x3C with two bytes queued
    push(8'h3C, n);
    push(8'h81, e);
    push(8'h42, e);
    wait_until(n + 45);
    #3 reset = 1'b0;
    #1;
    check("t5_txd",   TxD,      1'b1);
    check("t5_busy",  busy,     1'b0);
    check("t5_ready", tx_ready, 1'b1);
    repeat (2) tick();
    #2 reset = 1'b1;
    clear_rx();
    repeat (250) tick();
    check("t5_silent",    rx_b.size(), 0);
    check("t5_busy_post", busy, 1'b0);
    push(8'h96, n);
    wait_quiet();
    check("t5_new_count", rx_b.size(), 1);
    check("t5_new_byte",  rx_b[0], 8'h96);
    check("t5_new_start", rx_s[0], n + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART 8N1 transmitter with a small input FIFO. It is the transmit-side counterpart of the team's UART receiver on the Basys-3.
- Accepts bytes from fabric logic over a valid/ready handshake, buffers them, and serialises them LSB-first on TxD.
- Buffered bytes go out back-to-back at a fixed baud rate derived from the system clock.

Parameters:
- clk_freq, 100_000_000, system clock frequency in Hz.
- baud_rate, 921_600, line rate in bit/s.
- fifo_depth, 4, number of buffered bytes. Power of two, range 2..16.
- bit_clks, clk_freq/baud_rate (integer division; 108 at defaults), clock cycles per bit. Must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send, sampled on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- TxD  output  1  serial line, idle high.
- busy  output  1  a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - TxD=1, tx_ready=1, busy=0.
  - FIFO empty, state IDLE, baud and bit counters 0.
  - Mid-frame reset aborts the frame immediately; TxD returns high with no glitch low. Buffered bytes are discarded.
- Handshake:
  - Byte accepted on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_ready = FIFO not full, registered/derived from the count only; it never depends on tx_valid.
  - tx_data may change freely when not accepted.
  - tx_valid while tx_ready=0 is ignored; the source must hold it.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo fifo_depth.
  - Count range 0..fifo_depth.
  - Push and pop on the same edge leave the count unchanged. This is legal at any count < fifo_depth, including count 0? No: a pop requires count >= 1, so same-edge push+pop is legal for 1 <= count < fifo_depth.
  - Push into a full FIFO is impossible because tx_ready=0.
- State machine IDLE -> START -> DATA -> STOP:
  - IDLE: TxD=1. If FIFO non-empty, on the next edge pop the head into the shift register, clear the baud counter, enter START.
  - START: TxD=0 for bit_clks cycles.
  - DATA: 8 bits, LSB first, each held bit_clks cycles. The bit counter runs 0..7.
  - STOP: TxD=1 for bit_clks cycles. At the end:
    - FIFO non-empty: pop and go directly to START, with no idle cycles between frames.
    - FIFO empty: go to IDLE.
- Timing:
  - A byte accepted into an empty FIFO while IDLE at edge N drives TxD low from edge N+1.
  - Frame length is exactly 10*bit_clks cycles.
  - TxD is registered (glitch-free) and changes only on baud-counter wrap or state entry.
- Baud counter: counts 0..bit_clks-1 and wraps. Width is ceil(log2(bit_clks)).
- busy: 1 whenever state != IDLE or FIFO count != 0. It falls on the edge where STOP ends with the FIFO empty.
- Data isolation: the shift register content is independent of subsequent tx_data changes.

Test Plan:
(Sim parameters: clk_freq=1_000_000, baud_rate=100_000, bit_clks=10, fifo_depth=4.)
- Single byte: push 0xA5 at edge N.
  - Required: TxD low over [N+1, N+11).
  - Then bits 1,0,1,0,0,1,0,1, each 10 cycles.
  - Stop high for 10 cycles.
  - busy falls at N+101; TxD stays 1 afterwards.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - Required: the second start bit begins exactly 100 cycles after the first.
  - No idle-high gap beyond the stop bit.
  - Decoded bytes are 0x00, 0xFF.
- FIFO full: hold tx_valid=1 for 8 cycles with values 0x01..0x08.
  - Required: 5 bytes accepted (0x01..0x05); the first is popped immediately.
  - tx_ready low from edge N+5 until the first frame ends.
  - Then 0x06 is accepted. Line order is 0x01..0x06.
- Simultaneous push/pop: push on the exact edge the STOP of frame 1 ends, with count 1.
  - Required: count stays 1.
  - The next frame starts with no gap; no byte is lost or duplicated.
- Reset mid-frame: assert reset=0 during DATA bit 3 of 0x3C with 2 bytes queued.
  - Required: TxD=1, busy=0, tx_ready=1 asynchronously.
  - After release, no transmission occurs until a new push.
- Valid without ready: hold tx_valid with changing tx_data while the FIFO is full.
  - Required: no byte is captured until tx_ready=1.
  - The byte captured is tx_data on the accepting edge.
